// File: rtl/jump_redirect_unit.sv
// Fetch PC sequencer with J/JAL/JR redirection, JAL link write and misaligned-JR halt.
// Optional macro DELAY_SLOT_EN: jumps take effect after one delay-slot fetch.
module jump_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        instr_valid,
    input  logic        is_j,
    input  logic        is_jal,
    input  logic        is_jr,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        link_we,
    output logic [31:0] link_addr,
    output logic        misalign_err,
    output logic        slot_jump_err,
    output logic [1:0]  dbg_state_o
);

`ifdef DELAY_SLOT_EN
    localparam bit DSE = 1'b1;
`else
    localparam bit DSE = 1'b0;
`endif

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        SLOT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        redirect_q, redirect_d;
    logic        link_we_q, link_we_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        misalign_q, misalign_d;
    logic        slot_err_q, slot_err_d;

    logic        one_hot;
    logic        accept;
    logic        jr_misaligned;
    logic [31:0] jump_tgt;
    logic [31:0] pc_plus8;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;

    // Multi-hot jump class is treated as an ordinary instruction.
    assign one_hot       = (is_j ^ is_jal ^ is_jr) & ~(is_j & is_jal & is_jr);
    assign accept        = ~stall & instr_valid & one_hot;
    assign jr_misaligned = is_jr & (|jr_target[1:0]);
    assign jump_tgt      = is_jr ? jr_target : {pc_plus4[31:28], instr_index, 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        redirect_d  = 1'b0;
        link_we_d   = 1'b0;
        link_addr_d = link_addr_q;
        misalign_d  = misalign_q;
        slot_err_d  = 1'b0;
        case (state_q)
            SEQ: begin
                if (!stall) begin
                    if (accept && jr_misaligned) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end else if (accept) begin
                        if (is_jal) begin
                            link_we_d   = 1'b1;
                            link_addr_d = DSE ? pc_plus8 : pc_plus4;
                        end
                        if (DSE) begin
                            target_d = jump_tgt;
                            pc_d     = pc_plus4;
                            state_d  = SLOT;
                        end else begin
                            pc_d       = jump_tgt;
                            redirect_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            SLOT: begin
                // A jump sitting in the delay slot is dropped and flagged.
                if (!stall) begin
                    pc_d       = target_q;
                    target_d   = 32'd0;
                    redirect_d = 1'b1;
                    slot_err_d = accept;
                    state_d    = SEQ;
                end
            end
            HALT: begin
            end
            default: state_d = SEQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEQ;
            pc_q        <= RESET_PC;
            target_q    <= 32'd0;
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_addr_q <= 32'd0;
            misalign_q  <= 1'b0;
            slot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            redirect_q  <= redirect_d;
            link_we_q   <= link_we_d;
            link_addr_q <= link_addr_d;
            misalign_q  <= misalign_d;
            slot_err_q  <= slot_err_d;
        end
    end

    assign pc            = pc_q;
    assign redirect      = redirect_q;
    assign link_we       = link_we_q;
    assign link_addr     = link_addr_q;
    assign misalign_err  = misalign_q;
    assign slot_jump_err = DSE ? slot_err_q : 1'b0;
    assign dbg_state_o   = state_q;

endmodule
